// File: rtl/multi_column_game_controller_pkg.sv
// Shared state encoding and field widths for the multi-column game controller.
package game_pkg;
  localparam int LIVES_WIDTH = 4;
  localparam int LEVEL_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2
  } game_state_e;
endpackage

// File: rtl/multi_column_game_controller_if.sv
// Bundle between the game controller and the column instances / score display path.
interface multi_column_game_controller_if
  import game_pkg::*;
#(
  parameter int NUM_COLUMNS = 3,
  parameter int SCORE_WIDTH = 8
);
  logic                   start;
  logic [NUM_COLUMNS-1:0] correct;
  logic [NUM_COLUMNS-1:0] game_over;
  logic [NUM_COLUMNS-1:0] column_reset;
  logic                   fall_tick;
  logic [SCORE_WIDTH-1:0] score;
  logic [LIVES_WIDTH-1:0] lives;
  logic [LEVEL_WIDTH-1:0] level;
  logic [1:0]             state;

  modport master (
    output start, correct, game_over,
    input  column_reset, fall_tick, score, lives, level, state
  );

  modport slave (
    input  start, correct, game_over,
    output column_reset, fall_tick, score, lives, level, state
  );
endinterface

// File: rtl/multi_column_game_controller_fall_rate_timer.sv
// Free-running period counter; tick is a registered one-cycle strobe every `period` cycles.
module fall_rate_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        restart,
  output logic        tick
);
  logic [31:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (restart || !enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count >= period - 32'd1) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 32'd1;
      tick  <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_column_game_controller.sv
// Arbitrates NUM_COLUMNS falling-letter columns: staggered spawn, score, lives, level, fall rate.
//   state   | meaning
//   IDLE    | waiting for start, columns inactive
//   PLAYING | game running, columns spawn and fall
//   DEAD    | lives exhausted, everything frozen until start
module multi_column_game_controller
  import game_pkg::*;
#(
  parameter int NUM_COLUMNS = 3,
  parameter int SCORE_WIDTH = 8,
  parameter int LIVES       = 3,
  parameter int SPAWN_GAP   = 25000000,
  parameter int LEVEL_STEP  = 10,
  parameter int MAX_LEVEL   = 7,
  parameter int BASE_PERIOD = 12500000,
  parameter int PERIOD_STEP = 1250000,
  parameter int MIN_PERIOD  = 2500000
) (
  input logic                          clock,
  input logic                          reset,
  multi_column_game_controller_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_COLUMNS + 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  function automatic logic [3:0] popcount(input logic [NUM_COLUMNS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLUMNS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [3:0] b);
    logic [SCORE_WIDTH+3:0] sum;
    sum = {4'b0, a} + {{SCORE_WIDTH{1'b0}}, b};
    return (sum > {4'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_WIDTH-1:0];
  endfunction

  game_state_e            state_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic [LIVES_WIDTH-1:0] lives_q;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [NUM_COLUMNS-1:0] col_reset_q;
  logic [NUM_COLUMNS-1:0] spawned_q;
  logic [IDX_W-1:0]       spawn_idx_q;
  logic [31:0]            spawn_timer_q;

  logic [NUM_COLUMNS-1:0] hit, miss, spawn_pulse;
  logic [3:0]             hit_cnt, miss_cnt;
  logic [LIVES_WIDTH-1:0] lives_next;
  logic [LEVEL_WIDTH-1:0] level_target;
  logic [31:0]            level_quot, period;
  logic                   dying, level_up, spawn_pending, spawn_fire;
  logic                   timer_restart, timer_enable, tick;

  always_comb begin
    hit  = '0;
    miss = '0;
    if (state_q == PLAYING) begin
      hit  = bus.correct & spawned_q;
      // a match on the same column cancels its miss
      miss = bus.game_over & spawned_q & ~bus.correct;
    end
    hit_cnt    = popcount(hit);
    miss_cnt   = popcount(miss);
    lives_next = (lives_q > miss_cnt) ? lives_q - miss_cnt : '0;
    dying      = (state_q == PLAYING) && (miss != '0) && (lives_next == '0);

    level_quot   = 32'(score_q) / 32'(LEVEL_STEP);
    level_target = (level_quot > 32'(MAX_LEVEL)) ? LEVEL_WIDTH'(MAX_LEVEL)
                                                 : LEVEL_WIDTH'(level_quot);
    level_up     = (state_q == PLAYING) && (level_target > level_q);

    if (32'(level_q) * 32'(PERIOD_STEP) + 32'(MIN_PERIOD) >= 32'(BASE_PERIOD))
      period = 32'(MIN_PERIOD);
    else
      period = 32'(BASE_PERIOD) - 32'(level_q) * 32'(PERIOD_STEP);

    spawn_pending = 32'(spawn_idx_q) < 32'(NUM_COLUMNS);
    spawn_fire    = (state_q == PLAYING) && spawn_pending &&
                    (spawn_timer_q == 32'(SPAWN_GAP - 1));
    spawn_pulse   = spawn_fire ? (NUM_COLUMNS'(1) << spawn_idx_q) : '0;

    timer_restart = bus.start || level_up;
    timer_enable  = (state_q == PLAYING) && !dying;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      score_q       <= '0;
      lives_q       <= LIVES_WIDTH'(LIVES);
      level_q       <= '0;
      col_reset_q   <= '0;
      spawned_q     <= '0;
      spawn_idx_q   <= '0;
      spawn_timer_q <= '0;
    end else if (bus.start) begin
      // column 0 spawns on the entry cycle itself
      state_q       <= PLAYING;
      score_q       <= '0;
      lives_q       <= LIVES_WIDTH'(LIVES);
      level_q       <= '0;
      col_reset_q   <= NUM_COLUMNS'(1);
      spawned_q     <= NUM_COLUMNS'(1);
      spawn_idx_q   <= IDX_W'(1);
      spawn_timer_q <= '0;
    end else begin
      col_reset_q <= '0;
      if (state_q == PLAYING) begin
        score_q <= sat_add(score_q, hit_cnt);
        lives_q <= lives_next;
        if (level_up) level_q <= level_target;
        if (dying) begin
          state_q <= DEAD;
        end else begin
          col_reset_q <= hit | miss | spawn_pulse;
          spawned_q   <= spawned_q | spawn_pulse;
          if (spawn_fire) begin
            spawn_idx_q   <= spawn_idx_q + IDX_W'(1);
            spawn_timer_q <= '0;
          end else if (spawn_pending) begin
            spawn_timer_q <= spawn_timer_q + 32'd1;
          end
        end
      end
    end
  end

  fall_rate_timer u_fall_rate_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (timer_enable),
    .period  (period),
    .restart (timer_restart),
    .tick    (tick)
  );

  assign bus.column_reset = col_reset_q;
  assign bus.fall_tick    = tick;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.level        = level_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_multi_column_game_controller.sv
// Bench for the game controller: directed scenarios plus random play against a cycle-level rule model.
module tb_multi_column_game_controller;
  localparam int NC    = 3;
  localparam int SW    = 4;
  localparam int LV    = 3;
  localparam int GAP   = 4;
  localparam int STEP  = 2;
  localparam int MAXL  = 3;
  localparam int BASE  = 10;
  localparam int PSTEP = 2;
  localparam int MINP  = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multi_column_game_controller_if #(.NUM_COLUMNS(NC), .SCORE_WIDTH(SW)) bus ();

  multi_column_game_controller #(
    .NUM_COLUMNS(NC), .SCORE_WIDTH(SW), .LIVES(LV), .SPAWN_GAP(GAP),
    .LEVEL_STEP(STEP), .MAX_LEVEL(MAXL), .BASE_PERIOD(BASE),
    .PERIOD_STEP(PSTEP), .MIN_PERIOD(MINP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: expected outputs for the current cycle
  int m_state, m_score, m_lives, m_level, m_cr, m_tick;
  int m_age;  // cycles since PLAYING entry
  int m_r;    // age at which the fall timer last restarted

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int period_of(input int l);
    int p;
    p = BASE - l * PSTEP;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int spawned_mask(input int age);
    int m;
    m = 0;
    for (int i = 0; i < NC; i++) if (age >= i * GAP) m |= (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = LV; m_level = 0;
    m_cr = 0; m_tick = 0; m_age = 0; m_r = 0;
  endtask

  task automatic model_step(input logic s, input logic [NC-1:0] c, input logic [NC-1:0] g);
    int sp, vc, vm, nscore, nlives, nlevel, age1, spawn;
    if (s) begin
      m_state = 1; m_score = 0; m_lives = LV; m_level = 0;
      m_cr = 1; m_tick = 0; m_age = 0; m_r = 0;
      return;
    end
    if (m_state != 1) begin
      m_cr = 0; m_tick = 0;
      return;
    end
    sp = spawned_mask(m_age);
    vc = int'(c) & sp;
    vm = int'(g) & sp & ~int'(c);
    nscore = m_score + $countones(vc);
    if (nscore > 2**SW - 1) nscore = 2**SW - 1;
    nlives = m_lives - $countones(vm);
    if (nlives < 0) nlives = 0;
    nlevel = m_score / STEP;
    if (nlevel > MAXL) nlevel = MAXL;
    if (nlevel < m_level) nlevel = m_level;
    age1 = m_age + 1;
    spawn = 0;
    for (int i = 0; i < NC; i++) if (age1 == i * GAP) spawn |= (1 << i);
    if (nlevel != m_level) m_r = age1;
    m_score = nscore; m_lives = nlives; m_level = nlevel; m_age = age1;
    if (vm != 0 && nlives == 0) begin
      m_state = 2; m_cr = 0; m_tick = 0;
    end else begin
      m_cr   = vc | vm | spawn;
      m_tick = ((m_age - m_r) > 0 && ((m_age - m_r) % period_of(m_level)) == 0) ? 1 : 0;
    end
  endtask

  task automatic check_outputs();
    check_val("state",        32'(bus.state),        m_state);
    check_val("score",        32'(bus.score),        m_score);
    check_val("lives",        32'(bus.lives),        m_lives);
    check_val("level",        32'(bus.level),        m_level);
    check_val("column_reset", 32'(bus.column_reset), m_cr);
    check_val("fall_tick",    32'(bus.fall_tick),    m_tick);
  endtask

  // Called at a negedge: check this cycle, drive inputs, advance one cycle
  task automatic step(input logic s, input logic [NC-1:0] c, input logic [NC-1:0] g);
    check_outputs();
    bus.start = s; bus.correct = c; bus.game_over = g;
    model_step(s, c, g);
    @(negedge clock);
  endtask

  task automatic measure_period(input string tag, input int exp);
    int first, second;
    first = -1; second = -1;
    for (int k = 0; k < 40 && second < 0; k++) begin
      if (bus.fall_tick) begin
        if (first < 0) first = k; else second = k;
      end
      step(1'b0, '0, '0);
    end
    check_val(tag, (second < 0) ? 32'hFFFF_FFFF : 32'(second - first), exp);
  endtask

  initial begin
    logic             s;
    logic [NC-1:0]    c, g;
    bus.start = 1'b0; bus.correct = '0; bus.game_over = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    check_val("reset_lives", 32'(bus.lives), 3);
    reset = 1'b0;
    @(negedge clock);

    // start and staggered spawn: col0 at T+1, col1 at T+5, col2 at T+9
    step(1'b1, '0, '0);
    check_val("entry_state", 32'(bus.state), 1);
    check_val("spawn_col0", 32'(bus.column_reset), 1);
    repeat (4) step(1'b0, '0, '0);
    check_val("spawn_col1", 32'(bus.column_reset), 2);
    repeat (4) step(1'b0, '0, '0);
    check_val("spawn_col2", 32'(bus.column_reset), 4);
    step(1'b0, '0, '0);

    // two matches at once, level 1, period 8
    step(1'b0, 3'b011, '0);
    check_val("score_two", 32'(bus.score), 2);
    check_val("respawn_011", 32'(bus.column_reset), 3);
    step(1'b0, '0, '0);
    check_val("level_one", 32'(bus.level), 1);
    measure_period("period_l1", 8);

    // level 3 with period clamped at the floor
    step(1'b0, 3'b111, '0);
    step(1'b0, 3'b001, '0);
    check_val("score_six", 32'(bus.score), 6);
    repeat (2) step(1'b0, '0, '0);
    check_val("level_three", 32'(bus.level), 3);
    measure_period("period_floor", 6);
    step(1'b0, 3'b001, '0);
    repeat (2) step(1'b0, '0, '0);
    check_val("level_capped", 32'(bus.level), 3);

    // match beats miss on the same column
    step(1'b0, 3'b010, 3'b010);
    check_val("tie_score", 32'(bus.score), 8);
    check_val("tie_lives", 32'(bus.lives), 3);

    // three misses end the game; the last miss gets no respawn
    step(1'b0, '0, 3'b001);
    check_val("lives_two", 32'(bus.lives), 2);
    check_val("miss_respawn", 32'(bus.column_reset), 1);
    step(1'b0, '0, 3'b010);
    check_val("lives_one", 32'(bus.lives), 1);
    step(1'b0, '0, 3'b100);
    check_val("lives_zero", 32'(bus.lives), 0);
    check_val("dead_state", 32'(bus.state), 2);
    check_val("dead_no_respawn", 32'(bus.column_reset), 0);
    step(1'b0, 3'b111, '0);
    check_val("dead_frozen", 32'(bus.score), 8);

    // saturation at 15 for a 4-bit score
    step(1'b1, '0, '0);
    repeat (8) step(1'b0, '0, '0);
    repeat (6) step(1'b0, 3'b111, '0);
    check_val("score_sat", 32'(bus.score), 15);

    // asynchronous reset in the middle of the spawn sequence
    step(1'b1, '0, '0);
    repeat (2) step(1'b0, '0, '0);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_col_reset", 32'(bus.column_reset), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // random play
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 63) == 0);
      if (m_state != 1 && $urandom_range(0, 7) == 0) s = 1'b1;
      for (int i = 0; i < NC; i++) begin
        c[i] = ($urandom_range(0, 5) == 0);
        g[i] = ($urandom_range(0, 39) == 0);
      end
      step(s, c, g);
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
